// File: rtl/gbe_txs_status_pack.sv
// Transmit-side status collector for one 10GbE core: frame tracking, frame/overflow
// counters and sticky error flags packed into a single 32-bit status word.
module gbe_txs_status_pack #(
    parameter int unsigned MAX_WORDS = 1125,
    parameter int unsigned LEN_W     = 16
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic        tx_valid,
    input  logic        tx_end_of_frame,
    input  logic        tx_overflow,
    input  logic        tx_afull,
    input  logic        link_up,
    input  logic        cnt_rst,
    output logic [31:0] status_out
);

    localparam int unsigned FCNT_W = 24;
    localparam int unsigned OCNT_W = 3;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    wcnt_q, wcnt_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [OCNT_W-1:0]   ocnt_q, ocnt_d;
    logic                ovr_seen_q, ovr_seen_d;
    logic                oversize_q, oversize_d;
    logic                ovr_dly_q, ovr_dly_d;
    logic                link_q, link_d;
    logic                afull_q, afull_d;

    logic                in_frame_c;
    logic                frame_done_c;
    logic [LEN_W-1:0]    wcnt_inc_c;
    logic [LEN_W-1:0]    frame_len_c;
    logic                too_long_c;

    // FSM state register
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // FSM next state and word count
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (tx_valid) begin
            if (state_q == IDLE) begin
                if (!tx_end_of_frame) begin
                    state_d = IN_FRAME;
                    wcnt_d  = LEN_W'(1);
                end
            end else begin
                if (tx_end_of_frame) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_inc_c;
                end
            end
        end
    end

    // FSM outputs: completed-frame strobe and its length (single-word frames from IDLE are length 1)
    always_comb begin
        in_frame_c   = (state_q == IN_FRAME);
        wcnt_inc_c   = (wcnt_q == {LEN_W{1'b1}}) ? wcnt_q : wcnt_q + LEN_W'(1);
        frame_done_c = tx_valid & tx_end_of_frame;
        frame_len_c  = in_frame_c ? wcnt_inc_c : LEN_W'(1);
        too_long_c   = frame_len_c > LEN_W'(MAX_WORDS);
    end

    // Counters and sticky flags; clear overrides any same-cycle update
    always_comb begin
        fcnt_d     = frame_done_c ? fcnt_q + FCNT_W'(1) : fcnt_q;
        ocnt_d     = ocnt_q;
        if (tx_overflow && !ovr_dly_q && (ocnt_q != {OCNT_W{1'b1}})) begin
            ocnt_d = ocnt_q + OCNT_W'(1);
        end
        ovr_seen_d = ovr_seen_q | tx_overflow;
        oversize_d = oversize_q | (frame_done_c & too_long_c);
        ovr_dly_d  = tx_overflow;
        link_d     = link_up;
        afull_d    = tx_afull;
        if (cnt_rst) begin
            fcnt_d     = '0;
            ocnt_d     = '0;
            ovr_seen_d = 1'b0;
            oversize_d = 1'b0;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            fcnt_q     <= '0;
            ocnt_q     <= '0;
            ovr_seen_q <= 1'b0;
            oversize_q <= 1'b0;
            ovr_dly_q  <= 1'b0;
            link_q     <= 1'b0;
            afull_q    <= 1'b0;
        end else begin
            fcnt_q     <= fcnt_d;
            ocnt_q     <= ocnt_d;
            ovr_seen_q <= ovr_seen_d;
            oversize_q <= oversize_d;
            ovr_dly_q  <= ovr_dly_d;
            link_q     <= link_d;
            afull_q    <= afull_d;
        end
    end

    assign status_out = {link_q, afull_q, ovr_seen_q, oversize_q, state_q == IN_FRAME,
                         ocnt_q, fcnt_q};

endmodule

// File: tb/tb_gbe_txs_status_pack.sv
// Directed bench for gbe_txs_status_pack: reset, frame counting, oversize,
// overflow saturation, wrap/clear collision and mid-frame reset.
module tb_gbe_txs_status_pack;

    logic        clk = 1'b0;
    logic        user_rst;
    logic        tx_valid;
    logic        tx_end_of_frame;
    logic        tx_overflow;
    logic        tx_afull;
    logic        link_up;
    logic        cnt_rst;
    logic [31:0] status_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gbe_txs_status_pack dut (
        .user_clk        (clk),
        .user_rst        (user_rst),
        .tx_valid        (tx_valid),
        .tx_end_of_frame (tx_end_of_frame),
        .tx_overflow     (tx_overflow),
        .tx_afull        (tx_afull),
        .link_up         (link_up),
        .cnt_rst         (cnt_rst),
        .status_out      (status_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back frame; tx_valid is left high so the next frame can follow immediately
    task automatic send_frame(input int len);
        for (int i = 1; i <= len; i++) begin
            tx_valid        = 1'b1;
            tx_end_of_frame = (i == len);
            tick();
        end
        tx_end_of_frame = 1'b0;
    endtask

    task automatic idle_inputs();
        tx_valid        = 1'b0;
        tx_end_of_frame = 1'b0;
    endtask

    initial begin
        // Reset with every input high
        user_rst = 1'b1; tx_valid = 1'b1; tx_end_of_frame = 1'b1; tx_overflow = 1'b1;
        tx_afull = 1'b1; link_up = 1'b1; cnt_rst = 1'b1;
        tick();
        check("rst_c1", status_out, 32'h0000_0000);
        tick();
        check("rst_c2", status_out, 32'h0000_0000);

        user_rst = 1'b0; idle_inputs(); tx_overflow = 1'b0; cnt_rst = 1'b0;
        tx_afull = 1'b0;
        tick();
        check("rel_link", status_out, 32'h8000_0000);
        tx_afull = 1'b1;
        tick();
        check("rel_afull", status_out, 32'hC000_0000);
        tx_afull = 1'b0;
        tick();
        check("afull_drop", status_out, 32'h8000_0000);

        // Three back-to-back frames: 4, 1, 1125 words
        for (int i = 1; i <= 4; i++) begin
            tx_valid = 1'b1; tx_end_of_frame = (i == 4);
            tick();
            check($sformatf("in_frame_w%0d", i), 32'(status_out[27]), (i < 4) ? 32'd1 : 32'd0);
        end
        check("fcnt_f1", status_out, 32'h8000_0001);
        send_frame(1);
        check("fcnt_f2", status_out, 32'h8000_0002);
        send_frame(1125);
        idle_inputs();
        check("fcnt_f3_maxlen", status_out, 32'h8000_0003);
        tick();
        check("idle_hold", status_out, 32'h8000_0003);

        // Oversize frame, then a legal frame; flag stays until cleared
        send_frame(1126);
        idle_inputs();
        check("oversize_set", status_out, 32'h9000_0004);
        send_frame(10);
        idle_inputs();
        check("oversize_sticky", status_out, 32'h9000_0005);
        cnt_rst = 1'b1;
        tick();
        cnt_rst = 1'b0;
        check("cnt_rst_clear", status_out, 32'h8000_0000);

        // Nine overflow pulses, the second 5 cycles long
        for (int p = 0; p < 9; p++) begin
            tx_overflow = 1'b1;
            for (int c = 0; c < ((p == 1) ? 5 : 1); c++) begin
                tick();
                if (p == 0 && c == 0) check("ovr_edge_latency", status_out, 32'hA100_0000);
            end
            tx_overflow = 1'b0;
            tick();
            check($sformatf("ocnt_p%0d", p), status_out,
                  32'hA000_0000 | (32'((p + 1 > 7) ? 7 : p + 1) << 24));
        end
        cnt_rst = 1'b1;
        tick();
        cnt_rst = 1'b0;
        check("ovr_clear", status_out, 32'h8000_0000);

        // Frame counter wrap: preload the next-value path to 0xFFFFFF for one edge
        force dut.fcnt_d = 24'hFF_FFFF;
        tick();
        release dut.fcnt_d;
        check("fcnt_preload", status_out, 32'h80FF_FFFF);
        send_frame(1);
        idle_inputs();
        check("fcnt_wrap", status_out, 32'h8000_0000);
        send_frame(1);
        idle_inputs();
        check("fcnt_after_wrap", status_out, 32'h8000_0001);
        tx_valid = 1'b1; tx_end_of_frame = 1'b1; cnt_rst = 1'b1;
        tick();
        idle_inputs(); cnt_rst = 1'b0;
        check("clear_vs_eof", status_out, 32'h8000_0000);

        // Clear mid-frame: the frame in progress is still counted and length-checked
        for (int i = 1; i <= 1126; i++) begin
            tx_valid = 1'b1; tx_end_of_frame = (i == 1126); cnt_rst = (i == 600);
            tick();
        end
        idle_inputs(); cnt_rst = 1'b0;
        check("clear_mid_frame", status_out, 32'h9000_0001);
        cnt_rst = 1'b1;
        tick();
        cnt_rst = 1'b0;
        check("clear_again", status_out, 32'h8000_0000);

        // Reset mid-frame abandons the frame
        for (int i = 1; i <= 10; i++) begin
            tx_valid = 1'b1; tx_end_of_frame = 1'b0;
            tick();
        end
        check("mid_frame_flag", status_out, 32'h8800_0000);
        idle_inputs(); user_rst = 1'b1;
        tick();
        check("mid_rst", status_out, 32'h0000_0000);
        user_rst = 1'b0;
        send_frame(5);
        idle_inputs();
        check("after_mid_rst", status_out, 32'h8000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
